// File: rtl/acc_round_scheduler.sv
// acc_round_scheduler: drives the shared NTTN datapath through the FHEW blind-rotation rounds and the one-time twiddle load.
// Define ACC_SCHED_WATCHDOG_EN to add a sticky err_timeout that aborts a stalled INTT/NTT wait after WDOG_LIMIT cycles.
module acc_round_scheduler #(
  parameter int NUM_ROUNDS   = 1024,
  parameter int DIGITS       = 4,
  parameter int BEATS        = 64,
  parameter int DRAIN_CYCLES = 12,
  parameter int WLOAD_CYCLES = 1922,
  parameter int WDOG_LIMIT   = 4096,
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_req,
  input  logic          start,
  output logic          intt_start,
  input  logic          intt_done,
  output logic          ntt_start,
  input  logic          ntt_done,
  output logic          load_w,
  output logic          mac_en,
  output logic          key_rd_en,
  output logic [DW-1:0] digit_idx,
  output logic [RW-1:0] round_idx,
  output logic          busy,
  output logic          init_done,
  output logic          done,
  output logic          err_not_init
`ifdef ACC_SCHED_WATCHDOG_EN
  ,
  output logic          err_timeout
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WLOAD = 3'd1;
  localparam logic [2:0] S_INTT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_NTT   = 3'd4;
  localparam logic [2:0] S_MAC   = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  localparam int MAX_A   = (WLOAD_CYCLES > BEATS) ? WLOAD_CYCLES : BEATS;
  localparam int MAX_B   = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
  localparam int MAX_C   = (MAX_B > WDOG_LIMIT) ? MAX_B : WDOG_LIMIT;
  localparam int CW      = $clog2(MAX_C + 1);
  localparam int DRAIN_N = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES : 1;

  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};
  localparam logic [CW-1:0] WLOAD_LAST = CW'(WLOAD_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_N - 1);
  localparam logic [CW-1:0] BEAT_LAST  = CW'(BEATS - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
  localparam logic [RW-1:0] RND_LAST   = RW'(NUM_ROUNDS - 1);
`ifdef ACC_SCHED_WATCHDOG_EN
  localparam logic [CW-1:0] WDOG_LAST  = CW'(WDOG_LIMIT - 1);
`endif

  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dig_n;
  logic [RW-1:0] rnd_n;
  logic          init_done_n, err_not_init_n;
`ifdef ACC_SCHED_WATCHDOG_EN
  logic          err_timeout_n;
`endif

  always_comb begin
    nxt            = state;
    dig_n          = digit_idx;
    rnd_n          = round_idx;
    init_done_n    = init_done;
    err_not_init_n = err_not_init;
`ifdef ACC_SCHED_WATCHDOG_EN
    err_timeout_n  = err_timeout;
`endif
    case (state)
      S_IDLE: begin
        if (init_req) begin
          nxt = S_WLOAD;
        end else if (start && init_done) begin
          nxt   = S_INTT;
          dig_n = '0;
          rnd_n = '0;
        end else if (start) begin
          err_not_init_n = 1'b1;
        end
      end
      S_WLOAD: begin
        if (cnt == WLOAD_LAST) begin
          nxt         = S_IDLE;
          init_done_n = 1'b1;
        end
      end
      // A done pulse coinciding with our own start pulse cannot belong to this launch.
      S_INTT: begin
        if (intt_done && cnt != '0) begin
          nxt = S_DRAIN;
        end
`ifdef ACC_SCHED_WATCHDOG_EN
        else if (cnt == WDOG_LAST) begin
          nxt           = S_IDLE;
          err_timeout_n = 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          nxt   = S_NTT;
          dig_n = '0;
        end
      end
      S_NTT: begin
        if (ntt_done && cnt != '0) begin
          nxt = S_MAC;
        end
`ifdef ACC_SCHED_WATCHDOG_EN
        else if (cnt == WDOG_LAST) begin
          nxt           = S_IDLE;
          err_timeout_n = 1'b1;
        end
`endif
      end
      S_MAC: begin
        if (cnt == BEAT_LAST) begin
          if (digit_idx == DIG_LAST) begin
            nxt = S_NEXT;
          end else begin
            nxt   = S_NTT;
            dig_n = digit_idx + DW'(1);
          end
        end
      end
      S_NEXT: begin
        if (round_idx == RND_LAST) begin
          nxt = S_FIN;
        end else begin
          nxt   = S_INTT;
          rnd_n = round_idx + RW'(1);
          dig_n = '0;
        end
      end
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Every output is a flop fed from the next-state decode, so it is valid in the first cycle of its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      intt_start   <= 1'b0;
      ntt_start    <= 1'b0;
      load_w       <= 1'b0;
      mac_en       <= 1'b0;
      key_rd_en    <= 1'b0;
      digit_idx    <= '0;
      round_idx    <= '0;
      busy         <= 1'b0;
      init_done    <= 1'b0;
      done         <= 1'b0;
      err_not_init <= 1'b0;
`ifdef ACC_SCHED_WATCHDOG_EN
      err_timeout  <= 1'b0;
`endif
    end else begin
      state        <= nxt;
      cnt          <= (nxt != state) ? '0 : ((cnt == CNT_SAT) ? cnt : cnt + CW'(1));
      intt_start   <= (nxt == S_INTT) && (state != S_INTT);
      ntt_start    <= (nxt == S_NTT) && (state != S_NTT);
      load_w       <= (nxt == S_WLOAD);
      mac_en       <= (nxt == S_MAC);
      key_rd_en    <= (nxt == S_MAC);
      digit_idx    <= dig_n;
      round_idx    <= rnd_n;
      busy         <= (nxt != S_IDLE);
      init_done    <= init_done_n;
      done         <= (nxt == S_FIN);
      err_not_init <= err_not_init_n;
`ifdef ACC_SCHED_WATCHDOG_EN
      err_timeout  <= err_timeout_n;
`endif
    end
  end

endmodule

// File: tb/tb_acc_round_scheduler.sv
// Directed bench for acc_round_scheduler: twiddle load, start errors, full loops with an NTTN
// latency model, stray events, mid-run reset and (with ACC_SCHED_WATCHDOG_EN) the watchdog.
module tb_acc_round_scheduler;

  localparam int NR = 2, DG = 2, BT = 4, DR = 2, WL = 5, WD = 8;

  logic clk, reset, init_req, start, intt_done, ntt_done;
  logic intt_start, ntt_start, load_w, mac_en, key_rd_en, busy, init_done, done, err_not_init;
  logic [0:0] digit_idx, round_idx;
`ifdef ACC_SCHED_WATCHDOG_EN
  logic err_timeout;
`endif

  acc_round_scheduler #(
    .NUM_ROUNDS(NR), .DIGITS(DG), .BEATS(BT), .DRAIN_CYCLES(DR),
    .WLOAD_CYCLES(WL), .WDOG_LIMIT(WD)
  ) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .start(start),
    .intt_start(intt_start), .intt_done(intt_done),
    .ntt_start(ntt_start), .ntt_done(ntt_done),
    .load_w(load_w), .mac_en(mac_en), .key_rd_en(key_rd_en),
    .digit_idx(digit_idx), .round_idx(round_idx),
    .busy(busy), .init_done(init_done), .done(done), .err_not_init(err_not_init)
`ifdef ACC_SCHED_WATCHDOG_EN
    , .err_timeout(err_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NTTN model: answers done `lat` cycles after each start pulse.
  int   lat = 3;
  logic model_intt_en = 1'b1, model_ntt_en = 1'b1, stray_intt = 1'b0, stray_ntt = 1'b0;
  logic [7:0] intt_sr, ntt_sr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      intt_sr <= '0;
      ntt_sr  <= '0;
    end else begin
      intt_sr <= {intt_sr[6:0], intt_start};
      ntt_sr  <= {ntt_sr[6:0], ntt_start};
    end
  end
  assign intt_done = (model_intt_en & intt_sr[lat-1]) | stray_intt;
  assign ntt_done  = (model_ntt_en & ntt_sr[lat-1]) | stray_ntt;

  // Event monitor, sampled mid-cycle.
  int n_intt = 0, n_ntt = 0, n_mac = 0, n_done = 0, done_cyc = 0, run = 0, bad_run = 0, key_mis = 0;
  int dig_seq[64], rnd_seq[64];
  always @(negedge clk) begin
    if (intt_start) n_intt++;
    if (ntt_start) begin
      dig_seq[n_ntt % 64] = int'(digit_idx);
      rnd_seq[n_ntt % 64] = int'(round_idx);
      n_ntt++;
    end
    if (mac_en) begin
      n_mac++;
      run++;
    end else if (run != 0) begin
      if (run != BT) bad_run++;
      run = 0;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (key_rd_en != mac_en) key_mis++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({intt_start, ntt_start, load_w, mac_en, key_rd_en, digit_idx, round_idx,
                 busy, init_done, done, err_not_init});
  endfunction

  typedef struct {
    int lat;
    bit stray;
    int exp_intt;
    int exp_ntt;
    int exp_mac;
    int exp_done;
    int exp_cyc;
  } vec_t;

  // One full bootstrap loop; optional stray done/start/init_req pulses while MAC is active.
  task automatic run_vec(input int idx, input vec_t v);
    int b_intt, b_ntt, b_mac, b_done, b_bad, b_key, s_cyc;
    bit seen, stray_sent;
    b_intt = n_intt; b_ntt = n_ntt; b_mac = n_mac; b_done = n_done; b_bad = bad_run; b_key = key_mis;
    seen = 0; stray_sent = 0;
    lat = v.lat;
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (v.stray && mac_en && !stray_sent) begin
        stray_intt = 1'b1; stray_ntt = 1'b1; start = 1'b1; init_req = 1'b1;
        stray_sent = 1;
      end
      tick();
      stray_intt = 1'b0; stray_ntt = 1'b0; start = 1'b0; init_req = 1'b0;
      if (n_done != b_done) seen = 1;
    end
    chk($sformatf("v%0d_done_seen", idx), int'(seen), 1);
    tick();
    chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
    chk($sformatf("v%0d_intt_starts", idx), n_intt - b_intt, v.exp_intt);
    chk($sformatf("v%0d_ntt_starts", idx), n_ntt - b_ntt, v.exp_ntt);
    chk($sformatf("v%0d_mac_cycles", idx), n_mac - b_mac, v.exp_mac);
    chk($sformatf("v%0d_bad_runs", idx), bad_run - b_bad, 0);
    chk($sformatf("v%0d_key_rd_mismatch", idx), key_mis - b_key, 0);
    chk($sformatf("v%0d_done_pulses", idx), n_done - b_done, v.exp_done);
    chk($sformatf("v%0d_latency", idx), done_cyc - s_cyc, v.exp_cyc);
    for (int k = 0; k < NR * DG; k++) begin
      chk($sformatf("v%0d_digit_seq%0d", idx, k), dig_seq[(b_ntt + k) % 64], k % DG);
      chk($sformatf("v%0d_round_seq%0d", idx, k), rnd_seq[(b_ntt + k) % 64], k / DG);
    end
  endtask

  vec_t vt[4];
  int   lw_cnt, last_lw, first_id, beats, b0, k;
  bit   got;

  initial begin
    // Start-to-done cycles = 1 + NR*((lat+1) + DR + DG*((lat+1)+BT) + 1) = 6*lat + 29 here.
    vt[0] = '{3, 1'b0, 2, 4, 16, 1, 47};
    vt[1] = '{3, 1'b1, 2, 4, 16, 1, 47};
    vt[2] = '{1, 1'b0, 2, 4, 16, 1, 35};
    vt[3] = '{5, 1'b1, 2, 4, 16, 1, 59};

    reset = 1'b1; init_req = 1'b0; start = 1'b0;
    tick();
    chk("reset_outputs", outs(), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_outputs", outs(), 0);

    // start before any twiddle load
    b0 = n_intt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("noinit_err", int'(err_not_init), 1);
    chk("noinit_busy", int'(busy), 0);
    tick(); tick(); tick();
    chk("noinit_intt_starts", n_intt - b0, 0);

    // twiddle load; a start during WLOAD must be ignored
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    lw_cnt = 0; last_lw = -1; first_id = -1;
    for (int i = 0; i < 20; i++) begin
      if (load_w) begin lw_cnt++; last_lw = i; end
      if (init_done && first_id < 0) first_id = i;
      start = (i == 1);
      tick();
    end
    start = 1'b0;
    chk("wload_cycles", lw_cnt, WL);
    chk("init_done_after_load", first_id, last_lw + 1);
    chk("wload_busy_after", int'(busy), 0);
    chk("wload_no_intt", n_intt - b0, 0);

    for (int i = 0; i < 4; i++) run_vec(i, vt[i]);
    lat = 3;

    // init_req and start together from IDLE: load wins
    b0 = n_intt;
    init_req = 1'b1; start = 1'b1;
    tick();
    init_req = 1'b0; start = 1'b0;
    chk("simul_load_w", int'(load_w), 1);
    chk("simul_busy", int'(busy), 1);
    for (int i = 0; i < WL + 1; i++) tick();
    chk("simul_no_intt", n_intt - b0, 0);
    chk("simul_idle_after", int'(busy), 0);
    chk("simul_init_done", int'(init_done), 1);

    // reset on MAC beat 2 of round 1
    b0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    beats = 0;
    for (int i = 0; i < 200 && beats < 2; i++) begin
      if (mac_en && round_idx == 1'b1) beats++;
      if (beats < 2) tick();
    end
    chk("rst_reached_beat2", beats, 2);
    reset = 1'b1;
    #1;
    chk("rst_async_outputs", outs(), 0);
    tick();
    chk("rst_edge_outputs", outs(), 0);
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst_init_done_cleared", int'(init_done), 0);
    chk("rst_err_not_init", int'(err_not_init), 1);
    chk("rst_no_done", n_done - b0, 0);

`ifdef ACC_SCHED_WATCHDOG_EN
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 20 && !init_done; i++) tick();
    b0 = n_done;
    model_ntt_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (ntt_start) got = 1; else tick();
    end
    chk("wdog_ntt_start_seen", int'(got), 1);
    k = 0;
    while (!err_timeout && k < 50) begin
      tick();
      k++;
    end
    chk("wdog_timeout_cycles", k, WD);
    chk("wdog_busy", int'(busy), 0);
    tick();
    chk("wdog_idle_after", int'(busy), 0);
    chk("wdog_no_done", n_done - b0, 0);
    chk("wdog_init_done_kept", int'(init_done), 1);
    chk("wdog_mac_low", int'(mac_en), 0);
    model_ntt_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
